// File: rtl/pueo_thresh_pkg.sv
// Shared types and constants for the beam threshold loader and its register file.
package pueo_thresh_pkg;

    localparam int TBITS = 18;
    localparam logic [TBITS-1:0] DEFAULT_THRESH = 18'h3FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SHIFT,
        ST_COMMIT,
        ST_DONE
    } thr_load_state_t;

    function automatic int npair(input int nbeams);
        return (nbeams + 1) / 2;
    endfunction

endpackage

// File: rtl/thresh_regfile.sv
// Two-set threshold storage: one write port, one beam-pair read port.
// Optional readback port is built when THRESH_READBACK_EN is defined.
module thresh_regfile #(
    parameter int NBEAMS = 48,
    parameter int TBITS = 18,
    parameter logic [TBITS-1:0] DEFAULT_THRESH = '1,
    parameter int BW = 6,
    parameter int PW = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic               wset_i,
    input  logic [BW-1:0]      wbeam_i,
    input  logic [TBITS-1:0]   wdat_i,
    input  logic               rset_i,
    input  logic [PW-1:0]      rpair_i,
`ifdef THRESH_READBACK_EN
    input  logic               rb_rd_i,
    output logic [TBITS-1:0]   rb_dat_o,
    output logic               rb_valid_o,
`endif
    output logic [2*TBITS-1:0] rdat_o
);

    logic [TBITS-1:0] mem_q [2][NBEAMS];
    logic [TBITS-1:0] rd_lo, rd_hi;

    // Beam indices past NBEAMS match no entry, so such writes drop out naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < NBEAMS; b++)
                    mem_q[s][b] <= DEFAULT_THRESH;
        end else if (we_i) begin
            for (int b = 0; b < NBEAMS; b++)
                if (int'(wbeam_i) == b)
                    mem_q[wset_i][b] <= wdat_i;
        end
    end

    always_comb begin
        rd_lo = '0;
        rd_hi = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (b == 2 * int'(rpair_i))     rd_lo = mem_q[rset_i][b];
            if (b == 2 * int'(rpair_i) + 1) rd_hi = mem_q[rset_i][b];
        end
    end

    assign rdat_o = {rd_hi, rd_lo};

`ifdef THRESH_READBACK_EN
    logic [TBITS-1:0] rb_mux, rb_dat_q;
    logic             rb_valid_q;

    always_comb begin
        rb_mux = '0;
        for (int b = 0; b < NBEAMS; b++)
            if (int'(wbeam_i) == b)
                rb_mux = mem_q[wset_i][b];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rb_dat_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_dat_q   <= rb_mux;
            rb_valid_q <= rb_rd_i;
        end
    end

    assign rb_dat_o   = rb_dat_q;
    assign rb_valid_o = rb_valid_q;
`endif

endmodule

// File: rtl/beam_thresh_loader.sv
// Shifts a stored threshold set into the beamformer cascade chain, then commits it.
// Define THRESH_READBACK_EN to add the register-file readback port.
module beam_thresh_loader #(
    parameter int NBEAMS = 48,
    parameter int TBITS = pueo_thresh_pkg::TBITS,
    parameter logic [TBITS-1:0] DEFAULT_THRESH = pueo_thresh_pkg::DEFAULT_THRESH,
    localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               thr_we_i,
    input  logic               thr_set_i,
    input  logic [BW-1:0]      thr_beam_i,
    input  logic [TBITS-1:0]   thr_dat_i,
`ifdef THRESH_READBACK_EN
    input  logic               thr_rd_i,
    output logic [TBITS-1:0]   thr_rdat_o,
    output logic               thr_rvalid_o,
`endif
    input  logic [1:0]         load_req_i,
    output logic               load_busy_o,
    output logic [1:0]         load_done_o,
    output logic [2*TBITS-1:0] thresh_o,
    output logic [1:0]         thresh_wr_o,
    output logic [1:0]         thresh_update_o
);

    import pueo_thresh_pkg::*;

    localparam int NPAIR = npair(NBEAMS);
    localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    thr_load_state_t    state_q, state_d;
    logic [1:0]         pend_q, pend_d, pend_clr;
    logic               set_q, set_d;
    logic [PW-1:0]      pair_q, pair_d;
    logic               gap_q;
    logic [2*TBITS-1:0] thresh_q, slot_dat;
    logic [1:0]         wr_c, upd_c, done_c;

    thresh_regfile #(
        .NBEAMS(NBEAMS), .TBITS(TBITS), .DEFAULT_THRESH(DEFAULT_THRESH), .BW(BW), .PW(PW)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (thr_we_i),
        .wset_i  (thr_set_i),
        .wbeam_i (thr_beam_i),
        .wdat_i  (thr_dat_i),
        .rset_i  (set_q),
        .rpair_i (pair_q),
`ifdef THRESH_READBACK_EN
        .rb_rd_i   (thr_rd_i),
        .rb_dat_o  (thr_rdat_o),
        .rb_valid_o(thr_rvalid_o),
`endif
        .rdat_o  (slot_dat)
    );

    // gap_q holds off the next pick for one cycle after DONE, giving back-to-back loads an idle gap.
    always_comb begin
        state_d  = state_q;
        set_d    = set_q;
        pair_d   = pair_q;
        pend_clr = 2'b00;
        wr_c     = 2'b00;
        upd_c    = 2'b00;
        done_c   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if ((|pend_q) && !gap_q) begin
                    set_d    = ~pend_q[0];
                    pend_clr = pend_q[0] ? 2'b01 : 2'b10;
                    pair_d   = PW'(NPAIR - 1);
                    state_d  = ST_READ;
                end
            end
            ST_READ: state_d = ST_SHIFT;
            ST_SHIFT: begin
                wr_c[set_q] = 1'b1;
                if (pair_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    pair_d  = pair_q - 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_COMMIT: begin
                upd_c[set_q] = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                done_c[set_q] = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q & ~pend_clr) | load_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pend_q   <= 2'b00;
            set_q    <= 1'b0;
            pair_q   <= '0;
            gap_q    <= 1'b0;
            thresh_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            set_q   <= set_d;
            pair_q  <= pair_d;
            gap_q   <= (state_q == ST_DONE);
            if (state_q == ST_READ)
                thresh_q <= slot_dat;
        end
    end

    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = wr_c;
    assign thresh_update_o = upd_c;
    assign load_done_o     = done_c;
    assign load_busy_o     = (state_q != ST_IDLE) || (|pend_q);

endmodule

// File: doc/beam_thresh_loader.md
# beam_thresh_loader

Threshold transmitter for the dual-beam trigger array. Holds two threshold sets (set 0, set 1) for every beam in a local register file written by the control side. On request, it shifts a set into the beamformer's cascaded threshold chain over `thresh_o`/`thresh_wr_o`, then pulses `thresh_update_o` so the new values go live atomically. It sits between the register-bus decode and the beamform trigger, and is the only driver of that trigger's threshold inputs.

## Interface
Parameters:
- `NBEAMS`, 48: number of beams; `NPAIR = (NBEAMS+1)/2` chain slots.
- `TBITS`, 18: threshold width (fixed by the beam DSP threshold width).
- `DEFAULT_THRESH`, 18'h3FFFF: reset value of every stored threshold (never triggers).

Ports:
- `clk_i` in 1: single clock. All I/O is synchronous to it.
- `rst_i` in 1: reset, **asynchronous, active-high**.
- `thr_we_i` in 1: write strobe for the register file.
- `thr_set_i` in 1: set selected for the write.
- `thr_beam_i` in $clog2(NBEAMS): beam index for the write.
- `thr_dat_i` in TBITS: threshold value to write.
- `load_req_i` in 2: bit k requests a load of set k (single-cycle pulse).
- `load_busy_o` out 1: a load is in progress or pending.
- `load_done_o` out 2: bit k pulses for one cycle when set k is live.
- `thresh_o` out 2*TBITS: {beam 2p+1, beam 2p} thresholds for the current slot.
- `thresh_wr_o` out 2: bit k shifts `thresh_o` into set k's cascade chain.
- `thresh_update_o` out 2: bit k commits set k's chain.

## Operation
- Register file: 2×NBEAMS×TBITS flops, async reset to DEFAULT_THRESH. A write with `thr_beam_i >= NBEAMS` is ignored.
- Chain order: the first word shifted lands in the last pair. Slots are therefore sent for p = NPAIR-1 down to 0.
  - When NBEAMS is odd, the upper half of the last slot is 0.
- Pending register `pend[1:0]` ORs in `load_req_i` every cycle. It is cleared for set k when set k's load starts.
- FSM states:
  - IDLE: if any pending bit is set, select set k = lowest pending bit, clear `pend[k]`, set p = NPAIR-1, go to READ.
  - READ: register the slot-p data. Go to SHIFT.
  - SHIFT: drive `thresh_wr_o[k]`=1. If p==0, go to COMMIT; else p--, go to READ.
  - COMMIT: drive `thresh_update_o[k]`=1. Go to DONE.
  - DONE: drive `load_done_o[k]`=1. Return to IDLE.
- A simultaneous request for both sets loads set 0, then set 1, back to back.
- A request for the set currently loading, arriving during the load, is re-queued. A full reload follows.
- Register-file writes are accepted in every state.
  - A write to a slot not yet read appears in this load.
  - Otherwise it takes effect only on the next load.
  - A write and a read of the same beam in the same cycle: the read returns the old value.
- `load_busy_o` = (state != IDLE) | (|pend).
- Reset mid-load: the FSM goes to IDLE immediately and `pend` clears. The partial chain is never committed. Software must re-request.

## Timing
- Reset values: `thresh_o`=0, `thresh_wr_o`=0, `thresh_update_o`=0, `load_done_o`=0, `load_busy_o`=0. The FSM is in IDLE.
- Request pulse at cycle 0 (FSM idle):
  - `load_busy_o` rises at cycle 1.
  - `thresh_wr_o[k]` is high at cycles 3, 5, …, 2·NPAIR+1.
  - `thresh_o` holds slot data for the whole SHIFT cycle; it keeps its last value when not shifting.
  - `thresh_update_o[k]` pulses at cycle 2·NPAIR+2.
  - `load_done_o[k]` pulses at 2·NPAIR+3.
  - `load_busy_o` falls at 2·NPAIR+4 if nothing is pending.
- Write and update strobes are never asserted for both sets in the same cycle.
- Back-to-back loads have a 1-cycle IDLE gap.

## Configuration
- `THRESH_READBACK_EN` defined:
  - Adds `thr_rd_i` (in, 1), `thr_rdat_o` (out, TBITS) and `thr_rvalid_o` (out, 1).
  - A read of {`thr_set_i`, `thr_beam_i`} returns data one cycle later with `thr_rvalid_o`=1.
  - An out-of-range read returns 0.
  - The read has priority over nothing; it uses an independent mux.
- Undefined: none of these ports exist and no read mux is built.

## Structure
- Shared package `pueo_thresh_pkg`: TBITS, DEFAULT_THRESH, the FSM state enum `thr_load_state_t`, and the helper `npair(nbeams)`.
- Sub-module `thresh_regfile`: the 2×NBEAMS storage with one write port and a pair-read port. The readback port is added under the macro.

## Test plan
- Reset, no writes, NBEAMS=4, `load_req_i`=2'b01:
  - `thresh_wr_o[0]` at cycles 3 and 5, with `thresh_o`=36'hFFFFFFFFF both times.
  - update at 6, done at 7.
- NBEAMS=4, write beams 0..3 of set 1 = 10, 11, 12, 13, then request set 1:
  - `thresh_o` = {13,12} at cycle 3 and {11,10} at cycle 5.
  - Only bit 1 strobes.
- NBEAMS=3, write beams 0..2 of set 0 = 5, 6, 7, then load: slots sent are {0,7} then {6,5}.
- `load_req_i`=2'b11 at cycle 0, NBEAMS=4:
  - set 0 done at 7.
  - set 1 write strobes at 11 and 13, done at 15.
  - `load_busy_o` low at 16.
- Reset asserted during the second SHIFT: all outputs are 0 asynchronously, no update pulse, `load_busy_o`=0.
- With `THRESH_READBACK_EN`: write set 0 beam 2 = 300, then read it: `thr_rdat_o`=300 with `thr_rvalid_o` one cycle after `thr_rd_i`. Reading beam 9 when NBEAMS=4 returns 0.
